// File: rtl/d416_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : d416_scan_ctrl
//  Description : Sequential address generator for a 4-to-16 decoder.
//                It drives {e,x,y,z} through codes 0..15. Each code is
//                held for DWELL cycles in auto mode, or advanced once per
//                step pulse in step mode.
//                Optional macro SCAN_WRAP_EN: wrap 15->0 and keep
//                scanning until stop, pulsing done on each wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module d416_scan_ctrl #(
  parameter int DWELL = 10,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       step,
  input  logic       load,
  input  logic [3:0] load_code,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       e,
  output logic       valid,
  output logic       busy,
  output logic       done
);

`ifdef SCAN_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Terminal value of the dwell counter in auto mode.
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    code;
  logic [3:0]    start_code;
  logic [CW-1:0] dwell_cnt;
  logic          advance;

  // The code register is cleared whenever no scan is live, so it can drive
  // the decoder pins directly and they read zero outside a scan.
  assign {e, x, y, z} = code;

  // Moment to move to the next code: end of dwell in RUN, a step pulse in WAIT.
  assign advance = (state == S_RUN) ? (dwell_cnt == LAST_CNT) : step;

  // Scan state machine, code register, dwell counter and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      code       <= 4'd0;
      start_code <= 4'd0;
      dwell_cnt  <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load coincident with start takes effect for this scan.
          if (load) begin
            start_code <= load_code;
          end
          if (start) begin
            code      <= load ? load_code : start_code;
            dwell_cnt <= '0;
            valid     <= 1'b1;
            busy      <= 1'b1;
            state     <= mode ? S_WAIT : S_RUN;
          end
        end

        S_RUN, S_WAIT: begin
          // stop wins over every other event; start and load are ignored here.
          if (stop) begin
            state     <= S_IDLE;
            code      <= 4'd0;
            dwell_cnt <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
          end else if (advance) begin
            dwell_cnt <= '0;
            if ((code == 4'hF) && !WRAP_EN) begin
              state      <= S_DONE;
              code       <= 4'd0;
              start_code <= 4'd0;
              valid      <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              // Modulo-16 increment; in wrap builds 15->0 flags a pass.
              code <= code + 4'd1;
              done <= (code == 4'hF);
            end
          end else if (state == S_RUN) begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
